// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline stage: operand forwarding from MEM/WB, load-use stall detection,
// bubble insertion and the ID/EX register feeding the ALU.
module id_ex_operand_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs2,
  input  logic                  id_use_imm,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [DATA_W-1:0]     bus_a,
  input  logic [DATA_W-1:0]     bus_b,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_op_a,
  output logic [DATA_W-1:0]     ex_op_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [CNT_W-1:0]      bubble_count
);

  logic                  ex_valid_q, ex_valid_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  ex_mem_write_q, ex_mem_write_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0]     ex_op_a_q, ex_op_a_d;
  logic [DATA_W-1:0]     ex_op_b_q, ex_op_b_d;
  logic [DATA_W-1:0]     ex_store_data_q, ex_store_data_d;
  logic [CNT_W-1:0]      bubble_count_q, bubble_count_d;

  logic [DATA_W-1:0]     fwd_a, fwd_b;
  logic                  hazard_rs1, hazard_rs2;

  // R0 is hard-wired zero, so a pending write to index 0 must never be forwarded.
  always_comb begin
    fwd_a = bus_a;
    if (id_rs1 == '0)
      fwd_a = '0;
    else if (mem_reg_write && (mem_rd == id_rs1))
      fwd_a = mem_result;
    else if (wb_reg_write && (wb_rd == id_rs1))
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = bus_b;
    if (id_rs2 == '0)
      fwd_b = '0;
    else if (mem_reg_write && (mem_rd == id_rs2))
      fwd_b = mem_result;
    else if (wb_reg_write && (wb_rd == id_rs2))
      fwd_b = wb_data;
  end

  assign hazard_rs1 = (ex_rd_q == id_rs1);
  assign hazard_rs2 = id_use_rs2 && (ex_rd_q == id_rs2);
  assign stall = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                 (hazard_rs1 || hazard_rs2) && !flush;

  // Flush and stall both insert a bubble; only a stall is counted.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_rd_d         = ex_rd_q;
    ex_op_a_d       = ex_op_a_q;
    ex_op_b_d       = ex_op_b_q;
    ex_store_data_d = ex_store_data_q;
    bubble_count_d  = bubble_count_q;
    if (flush || stall) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      if (stall && (bubble_count_q != '1))
        bubble_count_d = bubble_count_q + 1'b1;
    end else begin
      ex_valid_d      = id_valid;
      ex_reg_write_d  = id_reg_write && id_valid;
      ex_mem_read_d   = id_mem_read && id_valid;
      ex_mem_write_d  = id_mem_write && id_valid;
      ex_rd_d         = id_rd;
      ex_op_a_d       = fwd_a;
      ex_op_b_d       = id_use_imm ? id_imm : fwd_b;
      ex_store_data_d = fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_rd_q         <= '0;
      ex_op_a_q       <= '0;
      ex_op_b_q       <= '0;
      ex_store_data_q <= '0;
      bubble_count_q  <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_rd_q         <= ex_rd_d;
      ex_op_a_q       <= ex_op_a_d;
      ex_op_b_q       <= ex_op_b_d;
      ex_store_data_q <= ex_store_data_d;
      bubble_count_q  <= bubble_count_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_rd         = ex_rd_q;
  assign ex_op_a       = ex_op_a_q;
  assign ex_op_b       = ex_op_b_q;
  assign ex_store_data = ex_store_data_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for forwarding/operand
// selection plus hand sequences for load-use stall, flush and async reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [2:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs2 = 1'b0, id_use_imm = 1'b0;
  logic [15:0] id_imm = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic [15:0] bus_a = '0, bus_b = '0;
  logic        flush = 1'b0;
  logic [2:0]  mem_rd = '0;
  logic        mem_reg_write = 1'b0;
  logic [15:0] mem_result = '0;
  logic [2:0]  wb_rd = '0;
  logic        wb_reg_write = 1'b0;
  logic [15:0] wb_data = '0;
  logic        stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_rd;
  logic [15:0] ex_op_a, ex_op_b, ex_store_data;
  logic [15:0] bubble_count;

  int total = 0;
  int bad = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .bus_a(bus_a), .bus_b(bus_b), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  rs1, rs2, rd;
    logic        use_rs2, use_imm;
    logic [15:0] imm;
    logic        rw, mr, mw;
    logic [15:0] ba, bb;
    logic        fl;
    logic [2:0]  mrd;
    logic        mrw;
    logic [15:0] mres;
    logic [2:0]  wrd;
    logic        wrw;
    logic [15:0] wdat;
    logic        e_valid, e_rw, e_mr, e_mw;
    logic [2:0]  e_rd;
    logic [15:0] e_a, e_b, e_sd;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_use_rs2 = v.use_rs2; id_use_imm = v.use_imm; id_imm = v.imm;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
    bus_a = v.ba; bus_b = v.bb; flush = v.fl;
    mem_rd = v.mrd; mem_reg_write = v.mrw; mem_result = v.mres;
    wb_rd = v.wrd; wb_reg_write = v.wrw; wb_data = v.wdat;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic clearFwd();
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    flush = 1'b0;
  endtask

  // Drive a valid load (rd=4) into EX so the next ID instruction can hit the hazard.
  task automatic loadIntoEx();
    clearFwd();
    id_valid = 1'b1; id_rs1 = 3'd1; id_rs2 = 3'd2; id_rd = 3'd4;
    id_use_rs2 = 1'b0; id_use_imm = 1'b1; id_imm = 16'h0010;
    id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b0;
    bus_a = 16'h0100; bus_b = 16'h0000;
    stepClock();
    checkOutput("load_in_ex_mr", {31'd0, ex_mem_read}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //        valid rs1   rs2   rd    ursr2 uimm  imm       rw    mr    mw    bus_a     bus_b     fl    mrd   mrw   mres      wrd   wrw   wdat       ev    erw   emr   emw   erd   e_a       e_b       e_sd
    vecs[0] = '{1'b1, 3'd6, 3'd5, 3'd1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0002, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0007, 16'h0002, 16'h0002};
    vecs[1] = '{1'b1, 3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 3'd3, 1'b1, 16'h1234, 3'd3, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h1234, 16'h2222, 16'h2222};
    vecs[2] = '{1'b1, 3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 3'd3, 1'b0, 16'h1234, 3'd3, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'hBEEF, 16'h2222, 16'h2222};
    vecs[3] = '{1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h6666, 1'b0, 3'd0, 1'b1, 16'hFFFF, 3'd0, 1'b1, 16'hEEEE, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 3'd4, 3'd2, 3'd3, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1010, 16'h2020, 1'b0, 3'd4, 1'b1, 16'h0C0C, 3'd2, 1'b1, 16'h0ABC, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0C0C, 16'h0ABC, 16'h0ABC};
    vecs[5] = '{1'b1, 3'd2, 3'd1, 3'd0, 1'b1, 1'b1, 16'hFFF9, 1'b0, 1'b0, 1'b1, 16'h3333, 16'h0001, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h3333, 16'hFFF9, 16'h0001};
    vecs[6] = '{1'b0, 3'd6, 3'd5, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0007, 16'h0002, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0007, 16'h0002, 16'h0002};
    vecs[7] = '{1'b1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h00A1, 16'h00B2, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h00A1, 16'h00B2, 16'h00B2};
    vecs[8] = '{1'b1, 3'd6, 3'd5, 3'd6, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h00A1, 16'h00B2, 16'h00B2};
    vecs[9] = '{1'b1, 3'd5, 3'd6, 3'd6, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0200, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0100, 16'h0042, 16'h0200};

    // Reset state, with a valid ID instruction present so stall is meaningful.
    id_valid = 1'b1;
    #2;
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("rst_bubble_count", {16'd0, bubble_count}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      stepClock();
      checkOutput($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      checkOutput($sformatf("v%0d_ex_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].e_rw});
      checkOutput($sformatf("v%0d_ex_mem_read", i), {31'd0, ex_mem_read}, {31'd0, vecs[i].e_mr});
      checkOutput($sformatf("v%0d_ex_mem_write", i), {31'd0, ex_mem_write}, {31'd0, vecs[i].e_mw});
      checkOutput($sformatf("v%0d_ex_rd", i), {29'd0, ex_rd}, {29'd0, vecs[i].e_rd});
      checkOutput($sformatf("v%0d_ex_op_a", i), {16'd0, ex_op_a}, {16'd0, vecs[i].e_a});
      checkOutput($sformatf("v%0d_ex_op_b", i), {16'd0, ex_op_b}, {16'd0, vecs[i].e_b});
      checkOutput($sformatf("v%0d_ex_store_data", i), {16'd0, ex_store_data}, {16'd0, vecs[i].e_sd});
    end
    checkOutput("table_bubble_count", {16'd0, bubble_count}, 32'd0);

    // Load-use on rs2: only a hazard when rs2 is actually read.
    loadIntoEx();
    id_valid = 1'b1; id_rs1 = 3'd7; id_rs2 = 3'd4; id_rd = 3'd5;
    id_use_rs2 = 1'b0; id_use_imm = 1'b0; id_mem_read = 1'b0; id_reg_write = 1'b1;
    bus_a = 16'h0070; bus_b = 16'h9999;
    #1;
    checkOutput("lu_no_use_rs2_stall", {31'd0, stall}, 32'd0);
    id_valid = 1'b0; id_use_rs2 = 1'b1;
    #1;
    checkOutput("lu_invalid_stall", {31'd0, stall}, 32'd0);
    id_valid = 1'b1;
    #1;
    checkOutput("lu_stall", {31'd0, stall}, 32'd1);
    stepClock();
    checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bubble_mr", {31'd0, ex_mem_read}, 32'd0);
    checkOutput("lu_bubble_count", {16'd0, bubble_count}, 32'd1);
    mem_rd = 3'd4; mem_reg_write = 1'b1; mem_result = 16'h00AA;
    #1;
    checkOutput("lu_stall_cleared", {31'd0, stall}, 32'd0);
    stepClock();
    checkOutput("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_ex_op_a", {16'd0, ex_op_a}, 32'h0070);
    checkOutput("lu_ex_op_b", {16'd0, ex_op_b}, 32'h00AA);
    checkOutput("lu_count_hold", {16'd0, bubble_count}, 32'd1);

    // Load-use on rs1, then flush in the same cycle suppresses the stall.
    loadIntoEx();
    id_valid = 1'b1; id_rs1 = 3'd4; id_rs2 = 3'd0; id_use_rs2 = 1'b0;
    id_mem_read = 1'b0; id_rd = 3'd2;
    #1;
    checkOutput("rs1_hazard_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    stepClock();
    checkOutput("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("flush_bubble_count", {16'd0, bubble_count}, 32'd1);

    // Immediate with store data, then asynchronous reset between edges.
    clearFwd();
    id_valid = 1'b1; id_rs1 = 3'd2; id_rs2 = 3'd1; id_rd = 3'd0;
    id_use_rs2 = 1'b1; id_use_imm = 1'b1; id_imm = 16'hFFF9;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b1;
    bus_a = 16'h0004; bus_b = 16'h0001;
    stepClock();
    checkOutput("imm_ex_op_b", {16'd0, ex_op_b}, 32'hFFF9);
    checkOutput("imm_ex_store_data", {16'd0, ex_store_data}, 32'h0001);
    checkOutput("imm_ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("arst_ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
    checkOutput("arst_ex_op_b", {16'd0, ex_op_b}, 32'h0000);
    checkOutput("arst_ex_store_data", {16'd0, ex_store_data}, 32'h0000);
    checkOutput("arst_bubble_count", {16'd0, bubble_count}, 32'd0);
    checkOutput("arst_stall", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage of the 16-bit, 8-register processor.
- Consumes the register file's combinational BusA/BusB read data and resolves data hazards by forwarding from MEM and WB.
- Detects load-use hazards, stalls upstream and inserts a bubble.
- Registers operands and control into the ID/EX pipeline register feeding the ALU; keeps a saturating stall counter for debug/performance.

Parameters:
- DATA_W, 16, datapath width (register, immediate, forwarding buses).
- REG_ADDR_W, 3, register index width (8 registers, R0 reads zero and is never written).
- CNT_W, 16, width of the stall/bubble performance counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source and destination indices (rs1/rs2 also drive register file RA/RB).
- id_use_rs2  in  1  instruction reads rs2 (ALU reg-reg or store data).
- id_use_imm  in  1  operand B is immediate instead of rs2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  decoded control.
- bus_a, bus_b  in  DATA_W  register file read data for rs1/rs2.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- mem_rd  in  REG_ADDR_W, mem_reg_write  in  1, mem_result  in  DATA_W  MEM-stage forwarding source.
- wb_rd  in  REG_ADDR_W, wb_reg_write  in  1, wb_data  in  DATA_W  WB-stage forwarding source (same bus driving register file BusW).
- stall  out  1  combinational: hold PC and IF/ID this cycle.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control.
- ex_rd  out  REG_ADDR_W  registered destination.
- ex_op_a, ex_op_b, ex_store_data  out  DATA_W  registered operands.
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, bubble_count 0; stall evaluates to 0 because ex_valid=0.
- Forwarding mux per source (rs1 → fwd_a, rs2 → fwd_b), combinational:
  - If index==0, value is 16'h0000; R0 is never forwarded.
  - Else if mem_reg_write and mem_rd==index, use mem_result.
  - Else if wb_reg_write and wb_rd==index, use wb_data.
  - Else use bus_a/bus_b.
  - MEM has priority over WB when both match.
- Operand selection:
  - ex_op_a = fwd_a.
  - ex_op_b = id_use_imm ? id_imm : fwd_b.
  - ex_store_data = fwd_b, always forwarded, even with id_use_imm.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)) & ~flush.
- Posedge update, priority flush > stall > load:
  - flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write ← 0; data fields don't-care (hold).
  - stall: same zeroing (bubble); bubble_count += 1, saturating at all-ones.
  - otherwise: ex_valid ← id_valid; controls ← id_* ANDed with id_valid; data fields ← selected operands; ex_rd ← id_rd.
- Stall always lasts exactly one cycle. The bubble clears ex_mem_read, so next cycle the load sits in MEM and its value arrives via mem_result.
- id_valid=0 loads a bubble; stall is never raised for invalid instructions.
- Writes to R0 with id_reg_write=1 pass through unchanged; the register file discards them and forwarding ignores index 0.
- Reset asserted mid-stall drops all state immediately; no pending bubble survives reset.
- No combinational path from ex_* outputs to themselves; stall depends on registered ex_* and current ID inputs only.

Test Plan:
- Reset → ex_valid=0, ex_reg_write=0, bubble_count=0, stall=0. Then load rs1=R6 (bus_a=0x0007), rs2=R5 (bus_b=0x0002), no forwarding → next cycle ex_op_a=0x0007, ex_op_b=0x0002.
- MEM forward: rs1=R3, mem_rd=3, mem_reg_write=1, mem_result=0x1234, wb_rd=3, wb_data=0xBEEF → ex_op_a=0x1234 (MEM beats WB). With mem_reg_write=0 → ex_op_a=0xBEEF.
- R0 guard: rs1=0, mem_rd=0, mem_reg_write=1, mem_result=0xFFFF → ex_op_a=0x0000.
- Load-use: EX holds a load with ex_rd=4; ID has rs2=4, id_use_rs2=1 → stall=1 for one cycle, next ex_valid=0, bubble_count=1. Following cycle stall=0; with mem_result=0x00AA, ex_op_b=0x00AA.
- Flush+hazard same cycle: load-use condition true and flush=1 → stall=0, ex_valid=0, bubble_count unchanged.
- Immediate/store: id_use_imm=1, id_imm=0xFFF9, rs2=R1 (bus_b=0x0001), id_mem_write=1 → ex_op_b=0xFFF9, ex_store_data=0x0001. Assert rst_n=0 mid-cycle → all ex_* clear asynchronously.
